// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared sizing constants and FSM state type for the fetch controller.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

  localparam int BUF_BYTES = 16;
  localparam int WIN_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_queue.sv
`default_nettype none
// ============================================================================
// Module : byte_queue
// Brief  : Byte FIFO with multi-byte pop and word append; oldest byte at [7:0].
// Rev    : 1.0
// ============================================================================
module byte_queue #(
  parameter int BUF_BYTES = fetch_pkg::BUF_BYTES,
  parameter int WIN_BYTES = fetch_pkg::WIN_BYTES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic [31:0]                   push_data,
  input  logic [2:0]                    push_len,
  input  logic [3:0]                    pop_len,
  output logic [$clog2(BUF_BYTES+1)-1:0] count,
  output logic [3:0]                    win_count,
  output logic [8*WIN_BYTES-1:0]        win_data
);
  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_BYTES + 1);

  logic [8*BUF_BYTES-1:0] mem, mem_nxt, shifted, pushed;
  logic [CW-1:0]          count_nxt, base;

  // Unused storage is kept zero, so a plain right shift both retires bytes and
  // leaves the window zero-filled; new bytes land just above the survivors.
  always_comb begin
    shifted   = mem >> {pop_len, 3'b000};
    base      = count - CW'(pop_len);
    pushed    = '0;
    count_nxt = base;
    if (push) begin
      pushed    = (8*BUF_BYTES)'(push_data) << {base, 3'b000};
      count_nxt = base + CW'(push_len);
    end
    mem_nxt = shifted | pushed;
    if (clear) begin
      mem_nxt   = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      count <= '0;
    end else begin
      mem   <= mem_nxt;
      count <= count_nxt;
    end
  end

  assign win_data  = mem[8*WIN_BYTES-1:0];
  assign win_count = (count > CW'(WIN_BYTES)) ? 4'(WIN_BYTES) : 4'(count);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_ctrl
// Brief  : Word fetcher feeding a byte window to an instruction decoder.
// Rev    : 1.0
// ============================================================================
module instr_fetch_ctrl #(
  parameter int BUF_BYTES = fetch_pkg::BUF_BYTES,
  parameter int WIN_BYTES = fetch_pkg::WIN_BYTES
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [31:0]            i_start_addr,
  output logic                   o_mem_req,
  output logic [31:0]            o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_data,
  output logic                   o_win_valid,
  output logic [8*WIN_BYTES-1:0] o_win_data,
  output logic [3:0]             o_win_count,
  output logic [31:0]            o_win_addr,
  input  logic                   i_consume,
  input  logic [3:0]             i_consume_len,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_addr,
  output logic                   o_busy,
  output logic                   o_err
);
  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_BYTES + 1);

  state_t        state, state_nxt;
  logic          pend, gap, err;
  logic [31:0]   fetch_ptr, req_addr, win_addr;
  logic [1:0]    skip;
  logic [CW-1:0] q_count;
  logic [3:0]    q_win_count;
  logic          ack_ok, issue, space_ok, consume_ok, consume_bad, clear, push;
  logic [3:0]    pop_len;
  logic [31:0]   push_data;
  logic [2:0]    push_len;

  assign ack_ok   = i_mem_ack && pend;
  assign space_ok = (q_count <= CW'(BUF_BYTES - 4));
  assign issue    = o_mem_req && !pend;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = FETCH;
      FETCH:   if (i_redirect && pend && !i_mem_ack) state_nxt = FLUSH;
      FLUSH:   if (ack_ok) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // The gap cycle after each ack keeps o_mem_req low for one cycle.
  always_comb begin
    o_busy    = (state != IDLE);
    o_mem_req = pend || (state == FETCH && !gap && !i_redirect && space_ok);
  end

  always_comb begin
    consume_ok  = i_consume && (q_count != '0) && (state == FETCH) && !i_redirect;
    consume_bad = consume_ok && ((i_consume_len == 4'd0) || (i_consume_len > q_win_count));
    pop_len     = 4'd0;
    if (consume_ok) pop_len = consume_bad ? ((i_consume_len == 4'd0) ? 4'd0 : q_win_count)
                                          : i_consume_len;
    push      = (state == FETCH) && ack_ok && !i_redirect;
    push_data = i_mem_data >> {skip, 3'b000};
    push_len  = 3'd4 - 3'(skip);
    clear     = ((state == IDLE) && i_start) || ((state != IDLE) && i_redirect);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend      <= 1'b0;
      gap       <= 1'b0;
      err       <= 1'b0;
      fetch_ptr <= '0;
      req_addr  <= '0;
      win_addr  <= '0;
      skip      <= '0;
    end else begin
      if (ack_ok)     pend <= 1'b0;
      else if (issue) pend <= 1'b1;
      gap <= ack_ok;
      if (issue) req_addr <= fetch_ptr;
      if (consume_bad) err <= 1'b1;
      if (state == IDLE) begin
        if (i_start) begin
          win_addr  <= i_start_addr;
          fetch_ptr <= {i_start_addr[31:2], 2'b00};
          skip      <= i_start_addr[1:0];
        end
      end else if (i_redirect) begin
        win_addr  <= i_redirect_addr;
        fetch_ptr <= {i_redirect_addr[31:2], 2'b00};
        skip      <= i_redirect_addr[1:0];
      end else begin
        win_addr <= win_addr + 32'(pop_len);
        if (push) begin
          fetch_ptr <= fetch_ptr + 32'd4;
          skip      <= 2'd0;
        end
      end
    end
  end

  byte_queue #(
    .BUF_BYTES (BUF_BYTES),
    .WIN_BYTES (WIN_BYTES)
  ) u_queue (
    .clk       (i_clk),
    .rst       (i_reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .push_len  (push_len),
    .pop_len   (pop_len),
    .count     (q_count),
    .win_count (q_win_count),
    .win_data  (o_win_data)
  );

  assign o_mem_addr  = pend ? req_addr : fetch_ptr;
  assign o_win_valid = (q_count != '0);
  assign o_win_count = q_win_count;
  assign o_win_addr  = win_addr;
  assign o_err       = err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_ctrl
// Brief  : Directed and random bench against a byte-queue reference model.
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam int BUF = 16;
  localparam int M_IDLE = 0, M_FETCH = 1, M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_mem_ack, i_consume, i_redirect;
  logic [31:0] i_start_addr, i_mem_data, i_redirect_addr;
  logic [3:0]  i_consume_len;
  logic        o_mem_req, o_win_valid, o_busy, o_err;
  logic [31:0] o_mem_addr, o_win_addr;
  logic [63:0] o_win_data;
  logic [3:0]  o_win_count;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_start_addr(i_start_addr),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_data(i_mem_data), .o_win_valid(o_win_valid), .o_win_data(o_win_data),
    .o_win_count(o_win_count), .o_win_addr(o_win_addr), .i_consume(i_consume),
    .i_consume_len(i_consume_len), .i_redirect(i_redirect),
    .i_redirect_addr(i_redirect_addr), .o_busy(o_busy), .o_err(o_err)
  );

  int total = 0, bad = 0;

  // Reference model: the fetched stream is a plain byte queue.
  logic [7:0]  q[$];
  int          mode, skip;
  logic [31:0] waddr, fptr, reqaddr;
  bit          pend, gap, err;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_data();
    logic [63:0] v = '0;
    for (int k = 0; k < 8 && k < q.size(); k++) v[8*k +: 8] = q[k];
    return v;
  endfunction

  function automatic bit exp_req(input bit rd);
    return pend || (mode == M_FETCH && !gap && !rd && (BUF - q.size()) >= 4);
  endfunction

  task automatic model_reset();
    q.delete();
    mode = M_IDLE; skip = 0; waddr = '0; fptr = '0; reqaddr = '0;
    pend = 0; gap = 0; err = 0;
  endtask

  task automatic check_outputs(input bit rd);
    bit req;
    req = exp_req(rd);
    chk_val("win_valid", 64'(o_win_valid), 64'(q.size() != 0));
    chk_val("win_count", 64'(o_win_count), 64'((q.size() > 8) ? 8 : q.size()));
    chk_val("win_data", o_win_data, exp_data());
    chk_val("win_addr", 64'(o_win_addr), 64'(waddr));
    chk_val("busy", 64'(o_busy), 64'(mode != M_IDLE));
    chk_val("err", 64'(o_err), 64'(err));
    chk_val("mem_req", 64'(o_mem_req), 64'(req));
    if (req) chk_val("mem_addr", 64'(o_mem_addr), 64'(pend ? reqaddr : fptr));
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input bit st, input logic [31:0] sa, input bit ack, input logic [31:0] d,
                       input bit cons, input logic [3:0] len, input bit rd, input logic [31:0] ra);
    bit ack_ok, issue;
    int n, wc;
    #1;
    i_start = st; i_start_addr = sa; i_mem_ack = ack; i_mem_data = d;
    i_consume = cons; i_consume_len = len; i_redirect = rd; i_redirect_addr = ra;
    @(negedge clk);
    check_outputs(rd);
    issue  = exp_req(rd) && !pend;
    ack_ok = ack && pend;
    if (issue) reqaddr = fptr;
    if (mode == M_IDLE) begin
      if (st) begin
        q.delete(); waddr = sa; fptr = {sa[31:2], 2'b00}; skip = int'(sa[1:0]); mode = M_FETCH;
      end
    end else if (rd) begin
      q.delete(); waddr = ra; fptr = {ra[31:2], 2'b00}; skip = int'(ra[1:0]);
      if (mode == M_FETCH) mode = (pend && !ack_ok) ? M_FLUSH : M_FETCH;
      else                 mode = ack_ok ? M_FETCH : M_FLUSH;
    end else if (mode == M_FLUSH) begin
      if (ack_ok) mode = M_FETCH;
    end else begin
      if (cons && q.size() > 0) begin
        wc = (q.size() > 8) ? 8 : q.size();
        if (len == 0 || int'(len) > wc) begin
          err = 1;
          n = (len == 0) ? 0 : wc;
        end else n = int'(len);
        repeat (n) void'(q.pop_front());
        waddr += 32'(n);
      end
      if (ack_ok) begin
        for (int b = skip; b < 4; b++) q.push_back(d[8*b +: 8]);
        skip = 0;
        fptr += 32'd4;
      end
    end
    if (ack_ok)     pend = 0;
    else if (issue) pend = 1;
    gap = ack_ok;
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic settle();
    #1;
    i_start = 0; i_mem_ack = 0; i_consume = 0; i_redirect = 0;
  endtask

  task automatic wait_pend();
    for (int i = 0; i < 20 && !pend; i++) idle();
    if (!pend) chk_val("wait_req_timeout", 64'(pend), 64'd1);
  endtask

  task automatic ack_word(input logic [31:0] d);
    wait_pend();
    cycle(0, '0, 1, d, 0, '0, 0, '0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    i_reset = 1; i_start = 0; i_mem_ack = 0; i_consume = 0; i_redirect = 0;
    #1;
    chk_val("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk_val("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    chk_val("rst_win_valid", 64'(o_win_valid), 64'd0);
    chk_val("rst_win_data", o_win_data, 64'd0);
    chk_val("rst_win_count", 64'(o_win_count), 64'd0);
    chk_val("rst_win_addr", 64'(o_win_addr), 64'd0);
    chk_val("rst_busy", 64'(o_busy), 64'd0);
    chk_val("rst_err", 64'(o_err), 64'd0);
    model_reset();
    @(posedge clk);
    #1 i_reset = 0;
    @(posedge clk);
  endtask

  initial begin
    bit          st, ack, cons, rd;
    logic [31:0] sa, d, ra;
    logic [3:0]  len;

    i_reset = 1; i_start = 0; i_start_addr = '0; i_mem_ack = 0; i_mem_data = '0;
    i_consume = 0; i_consume_len = '0; i_redirect = 0; i_redirect_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 i_reset = 0;
    @(posedge clk);
    do_reset();

    // Aligned start, two words fill the window.
    cycle(1, 32'h1000, 0, '0, 0, '0, 0, '0);
    ack_word(32'h04030201);
    ack_word(32'h08070605);
    settle();
    chk_val("t025_count", 64'(o_win_count), 64'd8);
    chk_val("t025_data", o_win_data, 64'h0807060504030201);
    chk_val("t025_addr", 64'(o_win_addr), 64'h1000);

    // Unaligned start drops leading bytes of the first word.
    do_reset();
    cycle(1, 32'h1002, 0, '0, 0, '0, 0, '0);
    settle();
    chk_val("t026_req", 64'(o_mem_req), 64'd1);
    chk_val("t026_mem_addr", 64'(o_mem_addr), 64'h1000);
    ack_word(32'hDDCCBBAA);
    settle();
    chk_val("t026_count", 64'(o_win_count), 64'd2);
    chk_val("t026_data", 64'(o_win_data[15:0]), 64'hDDCC);
    chk_val("t026_addr", 64'(o_win_addr), 64'h1002);

    // Back-pressure at 13 bytes, released by a consume.
    do_reset();
    cycle(1, 32'h0003, 0, '0, 0, '0, 0, '0);
    repeat (4) ack_word($urandom);
    idle(); idle();
    settle();
    chk_val("t027_req_held", 64'(o_mem_req), 64'd0);
    cycle(0, '0, 0, '0, 1, 4'd3, 0, '0);
    settle();
    chk_val("t027_count", 64'(o_win_count), 64'd8);
    chk_val("t027_req", 64'(o_mem_req), 64'd1);
    chk_val("t027_addr", 64'(o_win_addr), 64'h0006);

    // Redirect with a request in flight: stale data discarded.
    do_reset();
    cycle(1, 32'h0, 0, '0, 0, '0, 0, '0);
    wait_pend();
    cycle(0, '0, 0, '0, 0, '0, 1, 32'h2000);
    settle();
    chk_val("t028_flush_req", 64'(o_mem_req), 64'd1);
    chk_val("t028_flush_addr", 64'(o_mem_addr), 64'h0);
    cycle(0, '0, 1, 32'hFFFFFFFF, 0, '0, 0, '0);
    idle();
    settle();
    chk_val("t028_count", 64'(o_win_count), 64'd0);
    chk_val("t028_req", 64'(o_mem_req), 64'd1);
    chk_val("t028_mem_addr", 64'(o_mem_addr), 64'h2000);

    // Over-long consume: error, retire what is there.
    do_reset();
    cycle(1, 32'h1002, 0, '0, 0, '0, 0, '0);
    ack_word(32'h44332211);
    cycle(0, '0, 0, '0, 1, 4'd5, 0, '0);
    settle();
    chk_val("t029_err", 64'(o_err), 64'd1);
    chk_val("t029_count", 64'(o_win_count), 64'd0);
    chk_val("t029_addr", 64'(o_win_addr), 64'h1004);
    idle(); idle();
    settle();
    chk_val("t029_err_sticky", 64'(o_err), 64'd1);

    // Same-cycle ack and consume, then reset mid-request and a stray ack.
    do_reset();
    cycle(1, 32'h1002, 0, '0, 0, '0, 0, '0);
    ack_word(32'h44332211);
    ack_word(32'h88776655);
    wait_pend();
    cycle(0, '0, 1, 32'hCCBBAA99, 1, 4'd3, 0, '0);
    settle();
    chk_val("t030_count", 64'(o_win_count), 64'd7);
    wait_pend();
    do_reset();
    cycle(0, '0, 1, 32'h12345678, 0, '0, 0, '0);
    settle();
    chk_val("t030_idle_valid", 64'(o_win_valid), 64'd0);
    chk_val("t030_idle_busy", 64'(o_busy), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        st   = (mode == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        sa   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
        ack  = pend && ($urandom_range(0, 1) == 1);
        d    = $urandom;
        cons = ($urandom_range(0, 2) == 0);
        len  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        rd   = ($urandom_range(0, 24) == 0);
        ra   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
        cycle(st, sa, ack, d, cons, len, rd, ra);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
